// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory wait
// with timeout, plus saturating stall/flush counters and a sticky error.
module pipe_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int RW       = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          idex_memread,
    input  logic [RW-1:0] idex_rd,
    input  logic [RW-1:0] ifid_rs,
    input  logic [RW-1:0] ifid_rt,
    input  logic          exmem_branch,
    input  logic          exmem_zero,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          exmem_flush,
    output logic [1:0]    state,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        TIMEOUT  = 2'd3
    } state_t;

    localparam int          WW   = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

    state_t        st, st_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic          taken, hazard;
    logic          use_run, mem_term, haz_term;
    logic          flush_inc, set_err;

    assign taken  = exmem_branch & exmem_zero;
    assign hazard = idex_memread && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    assign state  = st;

    // Next state and enable/flush decode; the RUN rule set is shared by
    // RUN, LU_STALL and a completing MEM_WAIT with individual terms masked.
    always_comb begin
        st_nx       = st;
        wcnt_nx     = wcnt;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        flush_inc   = 1'b0;
        set_err     = 1'b0;
        use_run     = 1'b0;
        mem_term    = 1'b0;
        haz_term    = 1'b0;

        case (st)
            RUN: begin
                use_run  = 1'b1;
                mem_term = mem_req & ~mem_ready;
                haz_term = hazard;
            end
            LU_STALL: begin
                use_run  = 1'b1;
                mem_term = mem_req & ~mem_ready;
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    if (wcnt == WMAX) begin
                        st_nx   = TIMEOUT;
                        set_err = 1'b1;
                    end else begin
                        wcnt_nx = wcnt + 1'b1;
                    end
                end else begin
                    use_run  = 1'b1;
                    haz_term = hazard;
                end
            end
            default: ;  // TIMEOUT: frozen until reset
        endcase

        if (use_run) begin
            if (mem_term) begin
                wcnt_nx = WW'(1);
                st_nx   = MEM_WAIT;
            end else if (taken) begin
                {pc_en, ifid_en, idex_en, exmem_en}    = 4'b1111;
                {ifid_flush, idex_flush, exmem_flush}  = 3'b111;
                flush_inc = 1'b1;
                st_nx     = RUN;
            end else if (haz_term) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                idex_flush = 1'b1;
                st_nx      = LU_STALL;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                st_nx = RUN;
            end
        end

        // Nothing moves while reset is held.
        if (reset) begin
            {pc_en, ifid_en, idex_en, exmem_en}   = 4'b0000;
            {ifid_flush, idex_flush, exmem_flush} = 3'b000;
            flush_inc = 1'b0;
            set_err   = 1'b0;
        end
    end

    // State, wait counter, saturating counters and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st          <= RUN;
            wcnt        <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            st   <= st_nx;
            wcnt <= wcnt_nx;
            if (!pc_en && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (flush_inc && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            if (set_err) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl against a behavioural model
// that decides one "action" per cycle from the documented rule priorities.
module tb_pipe_ctrl;
    localparam int WAIT_MAX = 16;
    localparam int RW       = 5;

    // per-cycle actions of the model
    localparam int A_FREEZE = 0, A_BRANCH = 1, A_LOADUSE = 2, A_FLOW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          idex_memread = 1'b0;
    logic [RW-1:0] idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
    logic          exmem_branch = 1'b0, exmem_zero = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b1;
    logic          pc_en, ifid_en, idex_en, exmem_en;
    logic          ifid_flush, idex_flush, exmem_flush;
    logic [1:0]    state;
    logic [15:0]   stall_cnt, flush_cnt;
    logic          timeout_err;

    pipe_ctrl #(.WAIT_MAX(WAIT_MAX), .RW(RW)) dut (
        .clock(clock), .reset(reset),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: mode is the architectural state number (0..3)
    int m_mode, m_wait, m_stall, m_flush, m_err;
    int n_mode, n_wait, n_err, act;
    logic [6:0] exp_vec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observable enable/flush vector; idex_en only matters when not flushed.
    function automatic logic [6:0] dut_vec();
        return {pc_en, ifid_en, idex_en | idex_flush, exmem_en,
                ifid_flush, idex_flush, exmem_flush};
    endfunction

    // Pick this cycle's action from the current inputs and model mode.
    task automatic model_eval();
        bit hz, tk, mstall;
        hz = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt);
        tk = exmem_branch && exmem_zero;
        mstall = mem_req && !mem_ready;
        n_mode = m_mode; n_wait = m_wait; n_err = m_err;
        if (m_mode == 3) begin
            act = A_FREEZE;
        end else if (m_mode == 2 && !mem_ready) begin
            act = A_FREEZE;
            if (m_wait == WAIT_MAX) begin n_mode = 3; n_err = 1; end
            else n_wait = m_wait + 1;
        end else begin
            if (m_mode == 2) mstall = 0;   // access just completed
            if (m_mode == 1) hz = 0;       // stall already taken
            if (mstall)  begin act = A_FREEZE;  n_mode = 2; n_wait = 1; end
            else if (tk) begin act = A_BRANCH;  n_mode = 0; end
            else if (hz) begin act = A_LOADUSE; n_mode = 1; end
            else         begin act = A_FLOW;    n_mode = 0; end
        end
        case (act)
            A_BRANCH:  exp_vec = 7'b1111111;
            A_LOADUSE: exp_vec = 7'b0011010;
            A_FLOW:    exp_vec = 7'b1111000;
            default:   exp_vec = 7'b0000000;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_mode));
        chk({tag, ".stall"}, 32'(stall_cnt), 32'(m_stall));
        chk({tag, ".flush"}, 32'(flush_cnt), 32'(m_flush));
        chk({tag, ".err"},   32'(timeout_err), 32'(m_err));
    endtask

    // One clock of stimulus: check the combinational decode, then the
    // registered results after the edge.
    task automatic step(input logic mr, input logic [RW-1:0] rd, rs, rt,
                        input logic br, zr, rq, rdy, input bit quiet = 0);
        idex_memread = mr; idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
        exmem_branch = br; exmem_zero = zr; mem_req = rq; mem_ready = rdy;
        #1;
        model_eval();
        if (!quiet) chk("en_fl", 32'(dut_vec()), 32'(exp_vec));
        @(posedge clock); #1;
        if (exp_vec[6] == 1'b0 && m_stall < 16'hFFFF) m_stall++;
        if (act == A_BRANCH && m_flush < 16'hFFFF) m_flush++;
        m_mode = n_mode; m_wait = n_wait; m_err = n_err;
        if (!quiet) check_regs("reg");
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Asynchronous reset pulse asserted mid-cycle.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst.en_fl", 32'(dut_vec()), 32'd0);
        check_regs("rst");
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // Initial reset with live-looking inputs: outputs must stay quiet.
        idex_memread = 1; exmem_branch = 1; exmem_zero = 1; mem_ready = 1;
        #1;
        chk("rst0.en_fl", 32'(dut_vec()), 32'd0);
        check_regs("rst0");
        @(posedge clock); #1;
        reset = 1'b0;

        // Load-use hazard: exactly one stall cycle.
        step(1, 3, 3, 7, 0, 0, 0, 1);
        chk("lu.state", 32'(state), 32'd1);
        chk("lu.stall", 32'(stall_cnt), 32'd1);
        step(1, 3, 3, 7, 0, 0, 0, 1);     // hazard term masked in LU_STALL
        chk("lu.back", 32'(state), 32'd0);

        // Zero register never stalls.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("zero.state", 32'(state), 32'd0);

        // Branch and hazard together: flush only.
        do_reset();
        step(1, 3, 3, 0, 1, 1, 0, 1);
        chk("bh.flush", 32'(flush_cnt), 32'd1);
        chk("bh.stall", 32'(stall_cnt), 32'd0);
        chk("bh.state", 32'(state), 32'd0);

        // Memory wait: 3 stalled cycles, then release.
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mw.state", 32'(state), 32'd2);
        chk("mw.stall", 32'(stall_cnt), 32'd3);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("mw.rel", 32'(state), 32'd0);

        // Reset in the middle of a memory wait.
        step(0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        idle_step();

        // Timeout, bounded wait.
        begin
            int budget = 0;
            while (m_mode != 3 && budget < 4 * WAIT_MAX) begin
                step(0, 0, 0, 0, 0, 0, 1, 0);
                budget++;
            end
            chk("to.bound", 32'(budget < 4 * WAIT_MAX), 32'd1);
        end
        chk("to.state", 32'(state), 32'd3);
        chk("to.err", 32'(timeout_err), 32'd1);
        step(0, 0, 0, 0, 1, 1, 0, 1);     // branch ignored in TIMEOUT
        chk("to.hold", 32'(state), 32'd3);
        do_reset();
        chk("to.clr", 32'({state, timeout_err, stall_cnt, flush_cnt}), 32'd0);

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 250) == 249 || m_mode == 3) do_reset();
            step($urandom_range(0, 1), RW'($urandom_range(0, 3)),
                 RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0);
        end

        // Stall counter saturation via a frozen TIMEOUT state.
        do_reset();
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("sat.stall", 32'(stall_cnt), 32'hFFFF);
        chk("sat.model", 32'(stall_cnt), 32'(m_stall));
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("sat.nowrap", 32'(stall_cnt), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
